// File: rtl/cpu_control_fsm.sv
// Multicycle control FSM for the 16-bit CPU: fetch, PC update, decode and
// per-instruction execute sequencing with Moore-decoded datapath strobes.
module cpu_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] ALUop,
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic [1:0] nsel1,
    output logic [1:0] nsel2,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       pc_sel,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_B    = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
        S_WR_IMM, S_RD_B, S_PASS, S_WR_RD,
        S_RD_AB, S_EXEC,
        S_RD_A, S_ADDR, S_LADDR, S_MEM_RD, S_WB_MEM,
        S_RD_RD, S_PASS_S, S_MEM_WR,
        S_BRANCH, S_HALT
    } state_e;

    state_e state, state_next;
    logic   taken;

    // NOTE: reset is synchronous, so it lives inside the clocked block; state uses <= only.
    always_ff @(posedge clk) begin
        if (reset) state <= S_RST;
        else       state <= state_next;
    end

    // NOTE: every output and next-state gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        taken      = 1'b0;
        nsel1      = 2'b00;
        nsel2      = 2'b00;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = 2'b00;
        write      = 1'b0;
        load_ir    = 1'b0;
        load_pc    = 1'b0;
        reset_pc   = 1'b0;
        load_addr  = 1'b0;
        pc_sel     = 1'b0;
        addr_sel   = 1'b0;
        mem_cmd    = MEM_NONE;
        halted     = 1'b0;

        unique case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = Z;
            3'b010:  taken = ~Z;
            3'b011:  taken = N ^ V;
            3'b100:  taken = (N ^ V) | Z;
            default: taken = 1'b0;
        endcase

        unique case (state)
            S_RST: begin
                reset_pc   = 1'b1;
                load_pc    = 1'b1;
                state_next = S_IF1;
            end
            S_IF1: begin
                addr_sel   = 1'b1;
                mem_cmd    = MEM_READ;
                state_next = S_IF2;
            end
            S_IF2: begin
                addr_sel   = 1'b1;
                mem_cmd    = MEM_READ;
                load_ir    = 1'b1;
                state_next = S_UPD_PC;
            end
            S_UPD_PC: begin
                load_pc    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // Unrecognised opcode/ALUop combinations fall through as NOPs.
                state_next = S_IF1;
                case (opcode)
                    OP_MOV: begin
                        if (ALUop == 2'b10)      state_next = S_WR_IMM;
                        else if (ALUop == 2'b00) state_next = S_RD_B;
                    end
                    OP_ALU:         state_next = S_RD_AB;
                    OP_LDR, OP_STR: state_next = S_RD_A;
                    OP_B:           state_next = taken ? S_BRANCH : S_IF1;
                    OP_HALT:        state_next = S_HALT;
                    default:        state_next = S_IF1;
                endcase
            end
            S_WR_IMM: begin
                nsel1      = 2'b10;
                vsel       = 2'b10;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_RD_B: begin
                nsel2      = 2'b00;
                loadb      = 1'b1;
                state_next = S_PASS;
            end
            S_PASS: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_WR_RD;
            end
            S_WR_RD: begin
                nsel1      = 2'b01;
                vsel       = 2'b00;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_RD_AB: begin
                nsel1      = 2'b10;
                nsel2      = 2'b00;
                loada      = 1'b1;
                loadb      = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                loadc      = 1'b1;
                loads      = (ALUop == 2'b01);
                state_next = (ALUop == 2'b01) ? S_IF1 : S_WR_RD;
            end
            S_RD_A: begin
                nsel1      = 2'b10;
                loada      = 1'b1;
                state_next = S_ADDR;
            end
            S_ADDR: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_LADDR;
            end
            S_LADDR: begin
                load_addr  = 1'b1;
                state_next = (opcode == OP_STR) ? S_RD_RD : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_cmd    = MEM_READ;
                state_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                mem_cmd    = MEM_READ;
                nsel1      = 2'b01;
                vsel       = 2'b11;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_RD_RD: begin
                nsel2      = 2'b01;
                loadb      = 1'b1;
                state_next = S_PASS_S;
            end
            S_PASS_S: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_cmd    = MEM_WRITE;
                state_next = S_IF1;
            end
            S_BRANCH: begin
                load_pc    = 1'b1;
                pc_sel     = 1'b1;
                state_next = S_IF1;
            end
            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end
            default: state_next = S_RST;
        endcase
    end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multicycle control state machine for the 16-bit CPU. It sits directly downstream of the instruction decoder. It consumes the decoded `opcode`, `ALUop` and `cond` fields plus the status flags. It drives the decoder's `nsel1`/`nsel2` register selects and every load, mux-select and memory-command strobe in the datapath. The FSM sequences fetch, PC update, decode and per-instruction execute states, one state per clock.

## Interface
- No parameters. State encoding is internal and free.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high. Takes effect on the rising edge where it is high.
- `opcode`  in  3  from decoder: 110 MOV, 101 ALU, 011 LDR, 100 STR, 001 B, 111 HALT.
- `ALUop`  in  2  from decoder. For MOV: 10 is imm form, 00 is reg form. For ALU: 00 ADD, 01 CMP, 10 AND, 11 MVN.
- `cond`  in  3  from decoder (branch condition).
- `Z`, `N`, `V`  in  1 each  status register outputs.
- `nsel1`, `nsel2`  out  2 each  register select: 00 Rm, 01 Rd, 10 Rn.
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  datapath register enables.
- `asel`  out  1  1 forces ALU A input to 0.
- `bsel`  out  1  1 selects sximm5 on ALU B input.
- `vsel`  out  2  writeback source: 00 C, 10 sximm8, 11 mdata.
- `write`  out  1  register-file write enable.
- `load_ir`, `load_pc`, `reset_pc`, `load_addr`  out  1 each  fetch and addressing enables.
- `pc_sel`  out  1  0 selects PC+1, 1 selects PC+sximm8.
- `addr_sel`  out  1  1 selects the PC as memory address, 0 selects the data-address register.
- `mem_cmd`  out  2  00 NONE, 01 READ, 10 WRITE.
- `halted`  out  1  high in HALT.

## Operation
- All outputs are Moore, decoded from the current state only. Every output not listed for a state is 0.
- **RST:** `reset_pc`=1, `load_pc`=1. Next state is IF1.
- **IF1:** `addr_sel`=1, `mem_cmd`=READ.
- **IF2:** as IF1, plus `load_ir`=1.
- **UPD_PC:** `load_pc`=1, `pc_sel`=0.
- **DECODE:** no strobes. Dispatch:
  - MOV imm goes to WR_IMM.
  - MOV reg goes to RD_B.
  - ALU goes to RD_AB.
  - LDR and STR go to RD_A.
  - B taken goes to BRANCH. B not taken goes to IF1.
  - HALT goes to HALT.
  - Any other opcode/ALUop combination (000, 010, 110 with ALUop 01/11) is a NOP and goes to IF1.
- **WR_IMM:** `nsel1`=10, `vsel`=10, `write`=1. Next state is IF1.
- **RD_B (MOV reg):** `nsel2`=00, `loadb`=1.
- **PASS (MOV reg):** `asel`=1, `loadc`=1.
- **WR_RD (MOV reg):** `nsel1`=01, `vsel`=00, `write`=1. Next state is IF1.
- **RD_AB:** `nsel1`=10, `nsel2`=00, `loada`=1, `loadb`=1.
- **EXEC:** `loadc`=1, and `loads`=1 only when ALUop=01. CMP goes to IF1; all other ALU ops go to WR_RD.
- **LDR:** RD_A (`nsel1`=10, `loada`) → ADDR (`bsel`=1, `loadc`) → LADDR (`load_addr`) → MEM_RD (`addr_sel`=0, `mem_cmd`=READ) → WB_MEM (`mem_cmd`=READ held, `nsel1`=01, `vsel`=11, `write`) → IF1.
- **STR:** RD_A → ADDR → LADDR, as for LDR. Then RD_RD (`nsel2`=01, `loadb`) → PASS_S (`asel`=1, `loadc`) → MEM_WR (`addr_sel`=0, `mem_cmd`=WRITE) → IF1.
- **Branch conditions:**
  - 000 always taken.
  - 001 taken when Z.
  - 010 taken when !Z.
  - 011 taken when N≠V.
  - 100 taken when (N≠V) or Z.
  - 101–111 never taken.
- Flags are sampled in DECODE.
- **BRANCH:** `load_pc`=1, `pc_sel`=1. The PC already holds the next address, so the target is PC+1+sximm8 relative to the branch. Next state is IF1.
- **HALT:** `halted`=1, no other strobes. The FSM stays in HALT until `reset`.

## Timing
- Output reset values: the RST state outputs. `reset_pc`=`load_pc`=1; all others 0, including `halted`=0 and `mem_cmd`=00.
- `reset` high at any edge enters RST, overriding every transition including HALT. No `write` or `mem_cmd`=WRITE may appear in the cycle after a reset edge.
- Reset held for multiple cycles keeps the FSM in RST. IF1 follows on the first edge with `reset` low.
- Decoder fields must be stable from IF2+1 (IR loaded) until the instruction returns to IF1.
- Cycles from IF1 to the next IF1:
  - MOV imm: 5
  - MOV reg: 7
  - ALU: 7
  - CMP: 6
  - LDR: 9
  - STR: 10
  - B taken: 5
  - B not taken / NOP: 4
- `write` and `mem_cmd`=WRITE are each asserted for exactly one cycle per instruction. `load_ir` is asserted for exactly one cycle per fetch.

## Test plan
- Reset for 2 cycles, then release → RST outputs during reset. IF1 follows with `addr_sel`=1, `mem_cmd`=01. `load_ir` pulses exactly at IF2.
- MOV imm (opcode 110, ALUop 10) → `write`=1 with `nsel1`=10, `vsel`=10 on the 5th cycle after IF1. Back to IF1 on the 6th.
- ALU ADD, then CMP → ADD pulses `loada`/`loadb`, then `loadc`, then `write` with `nsel1`=01. CMP pulses `loads`=1 and never `write`. Periods are 7 and 6 cycles.
- LDR then STR → LDR: `load_addr` once, `mem_cmd`=01 with `addr_sel`=0 for 2 cycles, `vsel`=11 write. STR: `nsel2`=01 `loadb`, one `mem_cmd`=10 cycle, no `write`. Periods are 9 and 10 cycles.
- BEQ with Z=1 then Z=0, and BLE with N=0, V=1, Z=0 → BEQ with Z=1 asserts `pc_sel`=1, `load_pc`=1 in BRANCH (5-cycle period). BEQ with Z=0 returns to IF1 in 4 cycles. BLE is taken.
- HALT for 20 cycles, then reset asserted during LDR's MEM_RD → `halted`=1 is held and no strobes fire. Reset returns to RST in both cases with no `write` issued.
